dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits complete combinationally; misses stall the pipeline while a Moore FSM
// writes back a dirty victim and fills the 256-bit line over a req/ack handshake.
module dcache_ctrl #(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 27 - IDX_W;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_RESOLVE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Line address of the miss being serviced, captured when the miss is detected
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic             hit;
  logic             store_en;
  logic             wb_done;
  logic             fill_en;

  // Byte offset within a word carries no information for word accesses
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  assign req_idx  = addr_i[IDX_W+4:5];
  assign req_tag  = addr_i[31:IDX_W+5];
  assign word_sel = addr_i[4:2];
  assign hit      = req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag) & (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Miss address capture; no reset needed, only read outside IDLE
  always_ff @(posedge clk_i) begin
    miss_tag_q <= miss_tag_d;
    miss_idx_q <= miss_idx_d;
  end

  // Next-state, CPU-side and memory-side output decode
  always_comb begin
    state_d     = state_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    store_en    = 1'b0;
    wb_done     = 1'b0;
    fill_en     = 1'b0;
    rdata_o     = 32'h0;
    stall_o     = (state_q != S_IDLE) | (req_i & ~hit);
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (hit && !we_i) begin
          rdata_o = data_q[req_idx][{word_sel, 5'b0} +: 32];
        end
        if (hit && we_i) begin
          store_en = 1'b1;
        end
        if (req_i && !hit) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[miss_idx_q], miss_idx_q, 5'b0};
        mem_wdata_o = data_q[miss_idx_q];
        if (mem_ack_i) begin
          wb_done = 1'b1;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, 5'b0};
        if (mem_ack_i) begin
          fill_en = 1'b1;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Valid and dirty bits; reset invalidates the whole cache
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (store_en) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (fill_en) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; an in-flight update is dropped when reset hits
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (store_en) begin
        data_q[req_idx][{word_sel, 5'b0} +: 32] <= wdata_i;
      end
      if (fill_en) begin
        data_q[miss_idx_q] <= mem_rdata_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a line-wide memory model answers requests after a
// programmable latency, expected memory requests and load data go through queues.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
  logic         ack_r;
  logic         spur;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } mreq_t;

  mreq_t        exp_req_q[$];
  logic [31:0]  rd_q[$];
  int           starts[$];
  logic [255:0] mem_model [logic [26:0]];

  int checks  = 0;
  int passes  = 0;
  int n_req   = 0;
  int n_push  = 0;
  int mem_lat = 5;
  int cyc     = 0;

  assign mem_ack_i = ack_r | spur;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dcache_ctrl #(.NUM_LINES(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [26:0] key);
    logic [255:0] l;
    if (mem_model.exists(key)) return mem_model[key];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {8'hC0, key[20:0], 3'(w)};
    return l;
  endfunction

  task automatic expect_req(input logic we, input logic [31:0] a, input logic [255:0] wd);
    mreq_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    exp_req_q.push_back(e);
    n_push++;
  endtask

  // Present one access, count stall cycles, then check load data on the hit cycle
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall, input string tag);
    int n;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    rd_q.push_back(we ? 32'h0 : exp_rd);
    n = 0;
    @(negedge clk);
    while (stall_o && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall"}, 256'(n), 256'(exp_stall));
    chk({tag, "_rdata"}, 256'(rdata_o), 256'(rd_q.pop_front()));
  endtask

  // Memory model: checks each new request, acks after mem_lat request cycles
  initial begin
    mreq_t        e;
    logic [26:0]  key;
    int           cnt;
    ack_r = 1'b0; mem_rdata_i = '0; cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_r) begin
        ack_r = 1'b0;
        cnt   = 0;
      end
      if (!mem_req_o) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          n_req++;
          starts.push_back(cyc);
          if (exp_req_q.size() == 0) begin
            chk("unexpected_mem_req", 256'(mem_addr_o), 256'hFFFF_FFFF);
          end else begin
            e = exp_req_q.pop_front();
            chk("mem_we", 256'(mem_we_o), 256'(e.we));
            chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
            chk("mem_wdata", mem_wdata_o, e.wdata);
          end
        end
        cnt++;
        if (cnt >= mem_lat) begin
          ack_r = 1'b1;
          key   = mem_addr_o[31:5];
          if (mem_we_o) mem_model[key] = mem_wdata_o;
          else          mem_rdata_i = line_of(key);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ln;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; spur = 1'b0;
    ln = line_of(27'd2);
    ln[63:32] = 32'hDEAD_BEEF;
    mem_model[27'd2] = ln;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_stall", 256'(stall_o), 256'(0));
    chk("rst_rdata", 256'(rdata_o), 256'(0));
    chk("rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_mem_we", 256'(mem_we_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_mem_wdata", mem_wdata_o, 256'(0));

    // Cold load miss, ack after 5 request cycles
    mem_lat = 5;
    expect_req(1'b0, 32'h40, '0);
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 7, "cold_load");

    // Store hit, then loads of the same line
    access(1'b1, 32'h44, 32'h1234_5678, 32'h0, 0, "store_hit");
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 0, "load_after_store");
    ln = line_of(27'd2);
    access(1'b0, 32'h48, 32'h0, ln[95:64], 0, "load_word2");

    // Dirty conflict: writeback of the modified line, then fill of the new tag
    mem_lat = 3;
    ln[63:32] = 32'h1234_5678;
    expect_req(1'b1, 32'h40, ln);
    expect_req(1'b0, 32'h440, '0);
    ln = line_of(27'h22);
    access(1'b0, 32'h444, 32'h0, ln[63:32], 8, "dirty_conflict");

    // Evicted line comes back from memory with the stored word
    expect_req(1'b0, 32'h40, '0);
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 5, "refetch_victim");

    // Reset in the second ALLOCATE cycle
    mem_lat = 10;
    expect_req(1'b0, 32'h80, '0);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h84;
    @(posedge clk);
    @(posedge clk); #1;
    rst_i = 1'b1; req_i = 1'b0;
    @(negedge clk);
    chk("alloc2_mem_req", 256'(mem_req_o), 256'(1));
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("post_rst_stall", 256'(stall_o), 256'(0));
    mem_lat = 2;
    expect_req(1'b0, 32'h40, '0);
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 4, "miss_after_reset");

    // Idle: spurious ack with no request
    @(posedge clk); #1;
    req_i = 1'b0; spur = 1'b1;
    @(negedge clk);
    chk("idle_stall", 256'(stall_o), 256'(0));
    chk("idle_mem_req", 256'(mem_req_o), 256'(0));
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("idle_stall_after", 256'(stall_o), 256'(0));
    chk("idle_mem_req_after", 256'(mem_req_o), 256'(0));
    access(1'b0, 32'h44, 32'h0, 32'h1234_5678, 0, "idle_contents");

    // Back-to-back clean misses with single-cycle memory
    mem_lat = 1;
    starts.delete();
    expect_req(1'b0, 32'hA0, '0);
    expect_req(1'b0, 32'hC0, '0);
    ln = line_of(27'h5);
    access(1'b0, 32'hA0, 32'h0, ln[31:0], 3, "b2b_first");
    ln = line_of(27'h6);
    access(1'b0, 32'hC4, 32'h0, ln[63:32], 3, "b2b_second");
    if (starts.size() == 2) begin
      chk("b2b_req_gap", 256'(starts[1] - starts[0]), 256'(4));
    end else begin
      chk("b2b_req_count", 256'(starts.size()), 256'(2));
    end

    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("total_mem_reqs", 256'(n_req), 256'(n_push));
    chk("pending_exp_reqs", 256'(exp_req_q.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
